day8_ind_cell_arbiter: RTL and testbench
========================================

Name: day8_ind_cell_arbiter

Overview:
- Responder side of the shared index-cell lock protocol used by the Day 8 part 2 checkers.
- Holds the single "next cell to score" index register and grants exclusive lock to one checker at a time, round-robin.
- On release, commits the holder's proposed next index.
- Sits beside the checker array in the part 2 top; drives ind_cell_locked, ind_cell_locked_to and from_ind_cell to all checkers.

Parameters:
- ADDR_BITS, 16, width of grid byte addresses.
- ACTORS, 4, number of checkers; IDs are 0..ACTORS-1.
- START_IND, 0, index value loaded at reset; the top sets it to the first interior cell, MAX_C+2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low.
- ind_cell_lock_reqs  input  ACTORS  per-checker lock request, level-held.
- to_ind_cells  input  ACTORS x ADDR_BITS  per-checker proposed next index; stable while that checker's request falls.
- ind_cell_locked  output  1  lock currently granted.
- ind_cell_locked_to  output  $clog2(ACTORS+1)  holder ID; equals ACTORS when free.
- from_ind_cell  output  ADDR_BITS  current index register, driven continuously.
- commit_count  output  16  number of advancing commits, saturating at 16'hFFFF.

Behaviour:
- Interface decision: one clock, clk. Reset port rst is asynchronous and active-low.
- Reset (rst=0), applied immediately and independent of clk:
  - state=IcIdle, ind_cell_locked=0, ind_cell_locked_to=ACTORS.
  - index=START_IND, commit_count=0, rr_last=ACTORS-1.
- This reset holds even mid-grant; no commit occurs for an interrupted grant.
- State IcIdle:
  - If any request bit is set, pick a winner round-robin: scan IDs starting at (rr_last+1) mod ACTORS, wrapping, first set bit wins.
  - At the edge: ind_cell_locked<=1, ind_cell_locked_to<=winner, rr_last<=winner, state<=IcGranted.
  - With no requests, all registers hold.
- State IcGranted:
  - Holder request still high: all registers hold. Requests from other actors are ignored, no preemption.
  - Holder request low: this is the commit cycle. Sample to_ind_cells[holder] in the same cycle.
  - If the sample > index (unsigned), then index<=sample and commit_count increments (saturating). Otherwise index and commit_count hold.
  - A non-advancing release is the checker-completion path, where to_ind_cell keeps a stale value; index never moves backward.
  - In the same edge: ind_cell_locked<=0, ind_cell_locked_to<=ACTORS, state<=IcIdle.
- Latency:
  - Request seen in IcIdle produces a grant visible after 1 edge.
  - Holder release produces the new from_ind_cell and the lock drop after 1 edge.
  - The next grant comes 1 edge after that; the minimum lock turnaround is 2 cycles.
- The holder's request may already be low on the first IcGranted cycle (it is treated as an immediate release and commits normally).
- Simultaneous events:
  - A release and new requests in the same cycle: only the release is processed; the new requests are arbitrated in the following IcIdle cycle.
  - The releasing actor re-requesting right after its release is lowest priority on the next arbitration.
- from_ind_cell always equals the index register and is valid in the grant cycle, which checkers sample.
- Arithmetic: unsigned ADDR_BITS compare; no wrap, since the index only moves upward. commit_count is a saturating 16-bit counter.
- ind_cell_locked_to is always ACTORS when ind_cell_locked=0.

Decomposition:
- Package Day8IndCellPkg:
  - typedef enum IcState {IcIdle, IcGranted}.
  - Helper function for ID width, $clog2(ACTORS+1).
- Sub-module day8_rr_pick: combinational; inputs reqs[ACTORS] and last[ID width]; outputs valid and winner ID. Instantiated once.

Test Plan:
- Reset check (ACTORS=4, START_IND=102): assert rst=0 -> locked=0, locked_to=4, from_ind_cell=102, commit_count=0. Deassert with no requests for 5 cycles -> nothing changes.
- Single actor grant and commit:
  - Set req[2]=1 -> next edge locked=1, locked_to=2, from_ind_cell=102.
  - Set to_ind_cells[2]=103, then drop req[2] -> next edge from_ind_cell=103, locked=0, locked_to=4, commit_count=1.
- Round-robin fairness: after reset, raise req[0], req[1], req[3] together and release each 2 cycles after its grant -> grant order 0,1,3. Re-raise req[0] and req[1] -> order 0,1.
- Non-advancing release: with index=103, actor 1 holds and drops its request with to_ind_cells[1]=100 -> index stays 103, commit_count unchanged, lock freed.
- Hold and no preemption: actor 3 holds for 10 cycles while req[0]=1 -> locked_to stays 3 throughout. After actor 3 releases, actor 0 is granted 2 edges later.
- Reset mid-grant: while actor 2 holds with to_ind_cells[2]=150, pulse rst=0 between clock edges -> outputs take reset values immediately (from_ind_cell=102). No commit of 150. After reset is released, arbitration restarts with actor 0 highest priority.

Source files
------------

// File: rtl/day8_ind_cell_arbiter_pkg.sv
// Shared types and helpers for the Day 8 index-cell lock arbiter.
package day8_ind_cell_arbiter_pkg;

  // Arbiter lock state: free, or held by exactly one checker.
  typedef enum logic {
    IC_IDLE    = 1'b0,
    IC_GRANTED = 1'b1
  } ic_state_e;

  // Holder-ID width; one extra code (== actors) encodes "no holder".
  function automatic int unsigned id_width(input int unsigned actors);
    return $clog2(actors + 1);
  endfunction

endpackage

// File: rtl/day8_ind_cell_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last, wrapping.
module day8_rr_pick
  import day8_ind_cell_arbiter_pkg::*;
#(
  parameter int unsigned ACTORS = 4
) (
  input  logic [ACTORS-1:0]               reqs_i,
  input  logic [id_width(ACTORS)-1:0]     last_i,
  output logic                            valid_c,
  output logic [id_width(ACTORS)-1:0]     winner_c
);

  localparam int unsigned IdW = id_width(ACTORS);

  // Scan IDs last+1 .. last+ACTORS (mod ACTORS); the first requester wins.
  always_comb begin
    int unsigned idx;
    valid_c  = 1'b0;
    winner_c = IdW'(ACTORS);
    idx      = 0;
    for (int unsigned k = 1; k <= ACTORS; k++) begin
      idx = (32'(last_i) + k) % ACTORS;
      for (int unsigned j = 0; j < ACTORS; j++) begin
        if (!valid_c && (j == idx) && reqs_i[j]) begin
          valid_c  = 1'b1;
          winner_c = IdW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/day8_ind_cell_arbiter.sv
// Index-cell lock responder: round-robin grants one checker at a time and
// commits the holder's proposed index on release if it moves forward.
module day8_ind_cell_arbiter
  import day8_ind_cell_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned ACTORS    = 4,
  parameter int unsigned START_IND = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ACTORS-1:0]                   ind_cell_lock_reqs,
  input  logic [ACTORS-1:0][ADDR_BITS-1:0]    to_ind_cells,
  output logic                                ind_cell_locked,
  output logic [id_width(ACTORS)-1:0]         ind_cell_locked_to,
  output logic [ADDR_BITS-1:0]                from_ind_cell,
  output logic [15:0]                         commit_count
);

  localparam int unsigned IdW = id_width(ACTORS);
  localparam int unsigned CntW = 16;

  ic_state_e            state_q,     state_d;
  logic                 locked_q,    locked_d;
  logic [IdW-1:0]       locked_to_q, locked_to_d;
  logic [IdW-1:0]       rr_last_q,   rr_last_d;
  logic [ADDR_BITS-1:0] index_q,     index_d;
  logic [CntW-1:0]      count_q,     count_d;

  logic                 pick_valid_c;
  logic [IdW-1:0]       pick_winner_c;
  logic                 holder_req_c;
  logic [ADDR_BITS-1:0] holder_prop_c;

  day8_rr_pick #(
    .ACTORS (ACTORS)
  ) u_rr_pick (
    .reqs_i   (ind_cell_lock_reqs),
    .last_i   (rr_last_q),
    .valid_c  (pick_valid_c),
    .winner_c (pick_winner_c)
  );

  // Select the current holder's request level and proposed index.
  always_comb begin
    holder_req_c  = 1'b0;
    holder_prop_c = '0;
    for (int unsigned j = 0; j < ACTORS; j++) begin
      if (locked_to_q == IdW'(j)) begin
        holder_req_c  = ind_cell_lock_reqs[j];
        holder_prop_c = to_ind_cells[j];
      end
    end
  end

  // Next-state: grant from idle, commit-and-free on holder release.
  always_comb begin
    state_d     = state_q;
    locked_d    = locked_q;
    locked_to_d = locked_to_q;
    rr_last_d   = rr_last_q;
    index_d     = index_q;
    count_d     = count_q;
    case (state_q)
      IC_IDLE: begin
        if (pick_valid_c) begin
          locked_d    = 1'b1;
          locked_to_d = pick_winner_c;
          rr_last_d   = pick_winner_c;
          state_d     = IC_GRANTED;
        end
      end
      IC_GRANTED: begin
        if (!holder_req_c) begin
          // Stale proposals at or below the index are a completion, not a move.
          if (holder_prop_c > index_q) begin
            index_d = holder_prop_c;
            if (count_q != {CntW{1'b1}}) begin
              count_d = count_q + CntW'(1);
            end
          end
          locked_d    = 1'b0;
          locked_to_d = IdW'(ACTORS);
          state_d     = IC_IDLE;
        end
      end
      default: begin
        state_d     = IC_IDLE;
        locked_d    = 1'b0;
        locked_to_d = IdW'(ACTORS);
      end
    endcase
  end

  // State and datapath registers; reset abandons any grant without commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IC_IDLE;
      locked_q    <= 1'b0;
      locked_to_q <= IdW'(ACTORS);
      rr_last_q   <= IdW'(ACTORS - 1);
      index_q     <= ADDR_BITS'(START_IND);
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      locked_to_q <= locked_to_d;
      rr_last_q   <= rr_last_d;
      index_q     <= index_d;
      count_q     <= count_d;
    end
  end

  assign ind_cell_locked    = locked_q;
  assign ind_cell_locked_to = locked_to_q;
  assign from_ind_cell      = index_q;
  assign commit_count       = count_q;

endmodule

// File: tb/tb_day8_ind_cell_arbiter.sv
// Self-checking bench for day8_ind_cell_arbiter: directed vector table,
// hand-written corner sequences, and random traffic against a lock model.
module tb_day8_ind_cell_arbiter;

  localparam int unsigned AB = 16;
  localparam int unsigned NA = 4;
  localparam int unsigned SI = 102;
  localparam int unsigned IW = 3;

  logic                  clk;
  logic                  rst;
  logic [NA-1:0]         reqs;
  logic [NA-1:0][AB-1:0] props;
  logic                  locked;
  logic [IW-1:0]         locked_to;
  logic [AB-1:0]         from_ind;
  logic [15:0]           ccount;

  int errors;
  int checks;

  // Reference model state: holder is -1 when the lock is free.
  int          m_holder;
  int          m_rr_last;
  int unsigned m_index;
  int unsigned m_count;

  typedef struct {
    logic [NA-1:0] reqs;
    logic [AB-1:0] pval;
    logic          exp_locked;
    logic [IW-1:0] exp_to;
    logic [AB-1:0] exp_idx;
    logic [15:0]   exp_cnt;
  } vec_t;

  vec_t tbl[14];

  day8_ind_cell_arbiter #(
    .ADDR_BITS (AB),
    .ACTORS    (NA),
    .START_IND (SI)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ind_cell_lock_reqs (reqs),
    .to_ind_cells       (props),
    .ind_cell_locked    (locked),
    .ind_cell_locked_to (locked_to),
    .from_ind_cell      (from_ind),
    .commit_count       (ccount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_holder  = -1;
    m_rr_last = NA - 1;
    m_index   = SI;
    m_count   = 0;
  endtask

  // One clock edge of the lock protocol, from the behavioural rules.
  task automatic model_edge(input logic [NA-1:0] r, input logic [NA-1:0][AB-1:0] p);
    if (m_holder < 0) begin
      for (int k = 1; k <= NA; k++) begin
        int id;
        id = (m_rr_last + k) % NA;
        if (m_holder < 0 && r[id]) begin
          m_holder  = id;
          m_rr_last = id;
        end
      end
    end else if (!r[m_holder]) begin
      if (int'(p[m_holder]) > int'(m_index)) begin
        m_index = p[m_holder];
        if (m_count < 16'hFFFF) m_count++;
      end
      m_holder = -1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".locked"},    32'(locked),    (m_holder >= 0) ? 32'd1 : 32'd0);
    check({tag, ".locked_to"}, 32'(locked_to), (m_holder >= 0) ? 32'(m_holder) : 32'(NA));
    check({tag, ".index"},     32'(from_ind),  32'(m_index));
    check({tag, ".count"},     32'(ccount),    32'(m_count));
  endtask

  // Drive inputs, take one edge, advance the model, compare just after.
  task automatic step(input string tag, input logic [NA-1:0] r, input logic [NA-1:0][AB-1:0] p);
    reqs  = r;
    props = p;
    @(posedge clk);
    model_edge(r, p);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    reqs  = '0;
    props = '0;
    #1;
    check("rst.locked",    32'(locked),    32'd0);
    check("rst.locked_to", 32'(locked_to), 32'(NA));
    check("rst.index",     32'(from_ind),  32'(SI));
    check("rst.count",     32'(ccount),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [NA-1:0][AB-1:0] pv;
    logic [NA-1:0]         rq;
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    reqs   = '0;
    props  = '0;
    model_reset();

    tbl[0]  = '{4'b0000, 16'd0,   1'b0, 3'd4, 16'd102, 16'd0};
    tbl[1]  = '{4'b0100, 16'd0,   1'b1, 3'd2, 16'd102, 16'd0};
    tbl[2]  = '{4'b0100, 16'd103, 1'b1, 3'd2, 16'd102, 16'd0};
    tbl[3]  = '{4'b0000, 16'd103, 1'b0, 3'd4, 16'd103, 16'd1};
    tbl[4]  = '{4'b1011, 16'd103, 1'b1, 3'd3, 16'd103, 16'd1};
    tbl[5]  = '{4'b1011, 16'd100, 1'b1, 3'd3, 16'd103, 16'd1};
    tbl[6]  = '{4'b0011, 16'd100, 1'b0, 3'd4, 16'd103, 16'd1};
    tbl[7]  = '{4'b0011, 16'd100, 1'b1, 3'd0, 16'd103, 16'd1};
    tbl[8]  = '{4'b0010, 16'd110, 1'b0, 3'd4, 16'd110, 16'd2};
    tbl[9]  = '{4'b0011, 16'd110, 1'b1, 3'd1, 16'd110, 16'd2};
    tbl[10] = '{4'b0011, 16'd105, 1'b1, 3'd1, 16'd110, 16'd2};
    tbl[11] = '{4'b0001, 16'd105, 1'b0, 3'd4, 16'd110, 16'd2};
    tbl[12] = '{4'b0001, 16'd105, 1'b1, 3'd0, 16'd110, 16'd2};
    tbl[13] = '{4'b0000, 16'd200, 1'b0, 3'd4, 16'd200, 16'd3};

    #2;
    do_reset();

    // Idle after reset: nothing moves.
    for (int i = 0; i < 5; i++) begin
      step("idle", 4'b0000, '0);
      check("idle.index_const", 32'(from_ind), 32'(SI));
    end

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      reqs  = tbl[i].reqs;
      props = {NA{tbl[i].pval}};
      @(posedge clk);
      model_edge(reqs, props);
      #1;
      check($sformatf("vec%0d.locked", i),    32'(locked),    32'(tbl[i].exp_locked));
      check($sformatf("vec%0d.locked_to", i), 32'(locked_to), 32'(tbl[i].exp_to));
      check($sformatf("vec%0d.index", i),     32'(from_ind),  32'(tbl[i].exp_idx));
      check($sformatf("vec%0d.count", i),     32'(ccount),    32'(tbl[i].exp_cnt));
    end

    // Round-robin order after reset: 0,1,3 then 0,1.
    do_reset();
    step("rr", 4'b1011, '0); check("rr.grant0", 32'(locked_to), 32'd0);
    step("rr", 4'b1011, '0);
    step("rr", 4'b1010, '0);
    step("rr", 4'b1010, '0); check("rr.grant1", 32'(locked_to), 32'd1);
    step("rr", 4'b1010, '0);
    step("rr", 4'b1000, '0);
    step("rr", 4'b1000, '0); check("rr.grant3", 32'(locked_to), 32'd3);
    step("rr", 4'b1000, '0);
    step("rr", 4'b0000, '0);
    step("rr", 4'b0011, '0); check("rr.regrant0", 32'(locked_to), 32'd0);
    step("rr", 4'b0011, '0);
    step("rr", 4'b0010, '0);
    step("rr", 4'b0010, '0); check("rr.regrant1", 32'(locked_to), 32'd1);
    step("rr", 4'b0010, '0);
    step("rr", 4'b0000, '0);

    // Hold without preemption, then the waiter gets the lock 2 edges later.
    step("hold", 4'b1000, '0); check("hold.grant3", 32'(locked_to), 32'd3);
    for (int i = 0; i < 10; i++) begin
      step("hold", 4'b1001, '0);
      check("hold.still3", 32'(locked_to), 32'd3);
    end
    step("hold", 4'b0001, '0); check("hold.freed", 32'(locked), 32'd0);
    step("hold", 4'b0001, '0); check("hold.grant0", 32'(locked_to), 32'd0);
    step("hold", 4'b0000, '0);

    // Asynchronous reset during a grant: no commit of the pending proposal.
    pv = {NA{16'd150}};
    step("mid", 4'b0100, pv); check("mid.grant2", 32'(locked_to), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("mid.locked",    32'(locked),    32'd0);
    check("mid.locked_to", 32'(locked_to), 32'(NA));
    check("mid.index",     32'(from_ind),  32'(SI));
    check("mid.count",     32'(ccount),    32'd0);
    @(posedge clk);
    #1;
    check("mid.index_held", 32'(from_ind), 32'(SI));
    rst   = 1'b1;
    reqs  = '0;
    model_reset();
    step("post", 4'b1111, pv); check("post.grant0", 32'(locked_to), 32'd0);
    step("post", 4'b0000, pv);

    // Random level-held traffic against the model.
    rq = '0;
    for (int c = 0; c < 400; c++) begin
      for (int a = 0; a < NA; a++) begin
        if ($urandom_range(0, 3) == 0) rq[a] = ~rq[a];
        pv[a] = AB'(int'(m_index) + int'($urandom_range(0, 16)) - 8);
      end
      step("rand", rq, pv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
